// File: rtl/ysyx_23060077_lsu_pkg.sv
// Shared constants for the LSU: widths, funct3 size codes, AXI response codes
// and the one-hot FSM state encoding.
package ysyx_23060077_lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_ADDR_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_RD_ADDR = 6'b000010,
        S_RD_DATA = 6'b000100,
        S_WR_REQ  = 6'b001000,
        S_WR_RESP = 6'b010000,
        S_DONE    = 6'b100000
    } lsu_state_e;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_align.sv
// Byte-lane logic: load extraction with sign/zero extension, and store
// wdata replication plus wstrb generation. Lane rules assume a 32-bit bus.
module ysyx_23060077_lsu_align
    import ysyx_23060077_lsu_pkg::*;
(
    input  logic [1:0]                  i_addr_lo,
    input  logic [2:0]                  i_funct3,
    input  logic [LSU_DATA_WIDTH-1:0]   i_store_data,
    input  logic [LSU_DATA_WIDTH-1:0]   i_rdata,
    output logic [LSU_DATA_WIDTH-1:0]   o_load_data,
    output logic [LSU_DATA_WIDTH-1:0]   o_wdata,
    output logic [LSU_DATA_WIDTH/8-1:0] o_wstrb
);

    logic [LSU_DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
            F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
            default: o_load_data = w_shifted;
        endcase
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_wdata = {4{i_store_data[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wdata = {2{i_store_data[15:0]}};
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            default: begin
                o_wdata = i_store_data;
                o_wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060077_lsu.sv
// Load/store unit: one AXI4-Lite style transaction per memory instruction.
// Optional macro YSYX_23060077_LSU_FAULT_EN enables misalignment/response faults.
module ysyx_23060077_lsu
    import ysyx_23060077_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ex_to_ls,
    input  logic                    ls_to_wb,
    input  logic                    mem_ren,
    input  logic                    mem_wen,
    input  logic [2:0]              mem_funct3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic [DATA_WIDTH-1:0]   exu_result,
    output logic [DATA_WIDTH-1:0]   lsu_result,
    output logic                    lsu_finished,
    output logic                    lsu_busy,
    output logic                    lsu_fault,
    output logic [5:0]              dbg_state,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

`ifdef YSYX_23060077_LSU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    lsu_state_e              r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_store_data;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_finished;
    logic                    r_fault;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_aw_done;
    logic                    w_w_done;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_wstrb;

    // A DONE result can be retired and replaced in the same cycle.
    assign w_accept     = ex_to_ls && (r_state == S_IDLE || (r_state == S_DONE && ls_to_wb));
    assign w_misaligned = FAULT_EN && (mem_ren || mem_wen) && is_misaligned(mem_funct3, addr[1:0]);
    assign w_aw_done    = !r_awvalid || awready;
    assign w_w_done     = !r_wvalid || wready;

    ysyx_23060077_lsu_align u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_store_data (r_store_data),
        .i_rdata      (rdata),
        .o_load_data  (w_load_data),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_store_data <= '0;
            r_funct3     <= '0;
            r_result     <= '0;
            r_finished   <= 1'b0;
            r_fault      <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
        end else if (w_accept) begin
            r_addr       <= addr;
            r_store_data <= store_data;
            r_funct3     <= mem_funct3;
            r_finished   <= 1'b0;
            r_fault      <= 1'b0;
            if (w_misaligned) begin
                r_state    <= S_DONE;
                r_result   <= '0;
                r_finished <= 1'b1;
                r_fault    <= 1'b1;
            end else if (mem_ren) begin
                r_state   <= S_RD_ADDR;
                r_arvalid <= 1'b1;
            end else if (mem_wen) begin
                r_state   <= S_WR_REQ;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else begin
                r_state    <= S_DONE;
                r_result   <= exu_result;
                r_finished <= 1'b1;
            end
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        r_rready   <= 1'b0;
                        r_result   <= w_load_data;
                        r_fault    <= FAULT_EN && (rresp != RESP_OKAY);
                        r_finished <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_WR_REQ: begin
                    // AW and W complete independently, in either order.
                    if (awready) r_awvalid <= 1'b0;
                    if (wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        r_bready   <= 1'b0;
                        r_result   <= '0;
                        r_fault    <= FAULT_EN && (bresp != RESP_OKAY);
                        r_finished <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ls_to_wb) begin
                        r_finished <= 1'b0;
                        r_fault    <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_result   = r_result;
    assign lsu_finished = r_finished;
    assign lsu_busy     = !(r_state == S_IDLE || r_state == S_DONE);
    assign lsu_fault    = r_fault;
    assign dbg_state    = r_state;
    assign araddr       = r_addr;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;
    assign awaddr       = r_addr;
    assign awvalid      = r_awvalid;
    assign wdata        = r_wvalid ? w_wdata : '0;
    assign wstrb        = r_wvalid ? w_wstrb : '0;
    assign wvalid       = r_wvalid;
    assign bready       = r_bready;

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Directed bench for the LSU: vector table with a reactive AXI slave, plus
// hand sequences for back-to-back issue, ignored starts and mid-transaction reset.
module tb_ysyx_23060077_lsu;

`ifdef YSYX_23060077_LSU_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_DONE = 6'b100000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_to_ls, ls_to_wb, mem_ren, mem_wen;
    logic [2:0]  mem_funct3;
    logic [31:0] addr, store_data, exu_result;
    logic [31:0] lsu_result;
    logic        lsu_finished, lsu_busy, lsu_fault;
    logic [5:0]  dbg_state;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          ren;
        bit          wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exu;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_w;
        int          aw_w;
        int          w_w;
        logic [31:0] exp_result;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        bit          exp_fault;
        int          exp_bus;   // 0 none, 1 read, 2 write
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];
    vec_t vb;

    ysyx_23060077_lsu dut (
        .clock(clock), .reset(reset), .ex_to_ls(ex_to_ls), .ls_to_wb(ls_to_wb),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_funct3(mem_funct3), .addr(addr),
        .store_data(store_data), .exu_result(exu_result), .lsu_result(lsu_result),
        .lsu_finished(lsu_finished), .lsu_busy(lsu_busy), .lsu_fault(lsu_fault),
        .dbg_state(dbg_state), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic start_op(input vec_t v, input logic wb);
        mem_ren = v.ren; mem_wen = v.wen; mem_funct3 = v.f3; addr = v.addr;
        store_data = v.sdata; exu_result = v.exu;
        ex_to_ls = 1'b1; ls_to_wb = wb;
        @(negedge clock);
        ex_to_ls = 1'b0; ls_to_wb = 1'b0;
    endtask

    // Acts as the memory slave until lsu_finished, then checks the outcome.
    task automatic serve(input vec_t v, input int first_cycle, input string tag);
        int cyc = first_cycle;
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
        logic [3:0] ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        while (!lsu_finished && cyc < 60) begin
            check({tag, " busy"}, {31'h0, lsu_busy}, 32'h1);
            arready = arvalid && (ar_cnt >= v.ar_w);
            if (arvalid) begin
                check({tag, " araddr"}, araddr, v.addr);
                if (arready) ar_hs++;
                ar_cnt++;
            end
            rvalid = rready; rdata = v.rdata; rresp = v.resp;
            if (rready) r_hs++;
            awready = awvalid && (aw_cnt >= v.aw_w);
            if (awvalid) begin
                check({tag, " awaddr"}, awaddr, v.addr);
                if (awready) aw_hs++;
                aw_cnt++;
            end
            wready = wvalid && (w_cnt >= v.w_w);
            if (wvalid) begin
                check({tag, " wdata"}, wdata, v.exp_wdata);
                check({tag, " wstrb"}, {28'h0, wstrb}, {28'h0, v.exp_wstrb});
                if (wready) w_hs++;
                w_cnt++;
            end
            bvalid = bready; bresp = v.resp;
            if (bready) b_hs++;
            @(negedge clock);
            cyc++;
        end
        slave_idle();
        check({tag, " finished"}, {31'h0, lsu_finished}, 32'h1);
        check({tag, " latency"}, cyc, v.exp_lat);
        check({tag, " result"}, lsu_result, v.exp_result);
        check({tag, " fault"}, {31'h0, lsu_fault}, {31'h0, v.exp_fault});
        check({tag, " idle_busy"}, {31'h0, lsu_busy}, 32'h0);
        check({tag, " bus_hs"}, {12'h0, ar_hs, r_hs, aw_hs, w_hs, b_hs},
              (v.exp_bus == 1) ? 32'h00011000 : (v.exp_bus == 2) ? 32'h00000111 : 32'h0);
    endtask

    task automatic release_result(input string tag);
        ls_to_wb = 1'b1;
        @(negedge clock);
        ls_to_wb = 1'b0;
        check({tag, " released"}, {31'h0, lsu_finished}, 32'h0);
        check({tag, " fault_clr"}, {31'h0, lsu_fault}, 32'h0);
        check({tag, " state_idle"}, {26'h0, dbg_state}, {26'h0, ST_IDLE});
    endtask

    initial begin
        //        ren wen f3      addr          sdata         exu           rdata         rsp  ar aw w  exp_result    exp_wdata     strb     flt  bus lat
        vecs[0]  = '{0, 0, 3'b000, 32'h0,        32'h0,        32'h12345678, 32'h0,        2'b00, 0, 0, 0, 32'h12345678, 32'h0,        4'b0000, 0,   0,  1};
        vecs[1]  = '{1, 0, 3'b000, 32'h80000003, 32'h0,        32'h0,        32'h80FF0000, 2'b00, 0, 0, 0, 32'hFFFFFF80, 32'h0,        4'b0000, 0,   1,  3};
        vecs[2]  = '{1, 0, 3'b100, 32'h80000003, 32'h0,        32'h0,        32'h80FF0000, 2'b00, 0, 0, 0, 32'h00000080, 32'h0,        4'b0000, 0,   1,  3};
        vecs[3]  = '{1, 0, 3'b001, 32'h80000002, 32'h0,        32'h0,        32'hBEEF1234, 2'b00, 3, 0, 0, 32'hFFFFBEEF, 32'h0,        4'b0000, 0,   1,  6};
        vecs[4]  = '{1, 0, 3'b101, 32'h80000002, 32'h0,        32'h0,        32'hBEEF1234, 2'b00, 0, 0, 0, 32'h0000BEEF, 32'h0,        4'b0000, 0,   1,  3};
        vecs[5]  = '{1, 0, 3'b010, 32'h80000000, 32'h0,        32'h0,        32'hDEADBEEF, 2'b00, 0, 0, 0, 32'hDEADBEEF, 32'h0,        4'b0000, 0,   1,  3};
        vecs[6]  = '{1, 0, 3'b000, 32'h80000001, 32'h0,        32'h0,        32'h11227F44, 2'b00, 0, 0, 0, 32'h0000007F, 32'h0,        4'b0000, 0,   1,  3};
        vecs[7]  = '{0, 1, 3'b000, 32'h80000001, 32'h123456AB, 32'h0,        32'h0,        2'b00, 0, 0, 2, 32'h0,        32'hABABABAB, 4'b0010, 0,   2,  5};
        vecs[8]  = '{0, 1, 3'b000, 32'h80000001, 32'h123456AB, 32'h0,        32'h0,        2'b00, 0, 2, 0, 32'h0,        32'hABABABAB, 4'b0010, 0,   2,  5};
        vecs[9]  = '{0, 1, 3'b001, 32'h80000002, 32'h0000CAFE, 32'h0,        32'h0,        2'b00, 0, 1, 1, 32'h0,        32'hCAFECAFE, 4'b1100, 0,   2,  4};
        vecs[10] = '{0, 1, 3'b010, 32'h80000004, 32'h01020304, 32'h0,        32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h01020304, 4'b1111, 0,   2,  3};
        vecs[11] = '{0, 1, 3'b000, 32'h80000003, 32'h0000005A, 32'h0,        32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h5A5A5A5A, 4'b1000, 0,   2,  3};
        vecs[12] = '{1, 0, 3'b010, 32'h80000002, 32'h0,        32'h0,        32'hAABBCCDD, 2'b00, 0, 0, 0,
                     FEN ? 32'h0 : 32'h0000AABB, 32'h0, 4'b0000, FEN, FEN ? 0 : 1, FEN ? 1 : 3};
        vecs[13] = '{0, 1, 3'b010, 32'h80000008, 32'h55AA55AA, 32'h0,        32'h0,        2'b10, 0, 0, 0, 32'h0,        32'h55AA55AA, 4'b1111, FEN, 2,  3};
        vecs[14] = '{1, 0, 3'b100, 32'h80000000, 32'h0,        32'h0,        32'h000000C3, 2'b10, 0, 0, 0, 32'h000000C3, 32'h0,        4'b0000, FEN, 1,  3};
        vecs[15] = '{0, 1, 3'b001, 32'h80000001, 32'h00001234, 32'h0,        32'h0,        2'b00, 0, 0, 0,
                     32'h0, 32'h12341234, 4'b0011, FEN, FEN ? 0 : 2, FEN ? 1 : 3};
        vecs[16] = '{0, 0, 3'b010, 32'h80000002, 32'h0,        32'hFFFFFFFF, 32'h0,        2'b00, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        4'b0000, 0,   0,  1};
        vb       = '{1, 0, 3'b010, 32'h80000010, 32'h0,        32'h0,        32'h0BADF00D, 2'b00, 0, 0, 0, 32'h0BADF00D, 32'h0,        4'b0000, 0,   1,  4};

        reset = 1'b1; ex_to_ls = 1'b0; ls_to_wb = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        mem_funct3 = 3'b000; addr = '0; store_data = '0; exu_result = '0;
        slave_idle();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("reset outputs", {lsu_result, 4'h0}, 36'h0);
        check("reset ctrl", {24'h0, lsu_finished, lsu_busy, lsu_fault, arvalid, rready, awvalid, wvalid, bready}, 32'h0);
        check("reset bus", araddr | awaddr | wdata | {28'h0, wstrb}, 32'h0);
        check("reset state", {26'h0, dbg_state}, {26'h0, ST_IDLE});

        for (int i = 0; i < 17; i++) begin
            start_op(vecs[i], 1'b0);
            serve(vecs[i], 1, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Retire and issue in the same DONE cycle.
        start_op(vecs[0], 1'b0);
        serve(vecs[0], 1, "b2b first");
        start_op(vecs[5], 1'b1);
        serve(vecs[5], 1, "b2b second");
        release_result("b2b");

        // Start while busy is dropped; start in DONE without retire is dropped.
        start_op(vb, 1'b0);
        mem_ren = 1'b0; mem_wen = 1'b1; mem_funct3 = 3'b000; addr = 32'h90000000;
        store_data = 32'h77777777; ex_to_ls = 1'b1;
        @(negedge clock);
        ex_to_ls = 1'b0;
        serve(vb, 2, "busy ignore");
        mem_ren = 1'b0; mem_wen = 1'b0; exu_result = 32'hDEAD0000; ex_to_ls = 1'b1;
        @(negedge clock);
        ex_to_ls = 1'b0;
        check("done ignore result", lsu_result, 32'h0BADF00D);
        check("done ignore finished", {31'h0, lsu_finished}, 32'h1);
        check("done ignore state", {26'h0, dbg_state}, {26'h0, ST_DONE});
        release_result("done ignore");

        // Reset while waiting in RD_DATA.
        start_op(vecs[5], 1'b0);
        check("rst seq arvalid", {31'h0, arvalid}, 32'h1);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        check("rst seq rready", {31'h0, rready}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        check("rst seq ctrl", {24'h0, lsu_finished, lsu_busy, lsu_fault, arvalid, rready, awvalid, wvalid, bready}, 32'h0);
        check("rst seq state", {26'h0, dbg_state}, {26'h0, ST_IDLE});
        reset = 1'b0;
        @(negedge clock);
        check("rst seq after", {31'h0, lsu_finished}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_lsu.md
Name: ysyx_23060077_lsu

Overview:
- Load/store stage directly downstream of the execute unit.
- Takes the EXU adder sum as the effective address and src2 as store data. Issues one AXI4-Lite style memory transaction per memory instruction.
- Aligns and sign- or zero-extends load data, and forwards non-memory EXU results unchanged.
- Presents a registered result plus a finished/busy handshake to the writeback stage.

Parameters:
- DATA_WIDTH, 32, datapath and bus data width.
- ADDR_WIDTH, 32, memory address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_to_ls  in  1  start pulse; all inputs below are valid this cycle
- ls_to_wb  in  1  writeback consumed result; clears lsu_finished
- mem_ren  in  1  instruction is a load
- mem_wen  in  1  instruction is a store
- mem_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_WIDTH  effective address (EXU adder sum)
- store_data  in  DATA_WIDTH  store source (rs2)
- exu_result  in  DATA_WIDTH  EXU result for non-memory instructions
- lsu_result  out  DATA_WIDTH  registered result to writeback
- lsu_finished  out  1  result valid; held until ls_to_wb
- lsu_busy  out  1  transaction in flight (stall upstream)
- lsu_fault  out  1  access fault, qualified by lsu_finished (feature only)
- araddr  out  ADDR_WIDTH
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_WIDTH
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  ADDR_WIDTH
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_WIDTH
- wstrb  out  DATA_WIDTH/8
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset: all outputs 0; FSM to IDLE. A reset mid-transaction drops all valid/ready outputs the next cycle; the outstanding transaction is abandoned.
- FSM states:
  - IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, on ex_to_ls:
  - Latch addr, store_data, funct3 and exu_result.
  - mem_ren -> RD_ADDR. mem_wen -> WR_REQ.
  - Neither -> DONE, with lsu_result = exu_result.
  - mem_ren and mem_wen both set is illegal; load takes priority.
- RD_ADDR:
  - arvalid=1, araddr = latched addr (unaligned byte address passed through).
  - arvalid and araddr stay stable until arready.
  - On arvalid&arready -> RD_DATA.
- RD_DATA:
  - rready=1. On rvalid -> DONE; lsu_result <= extracted load data.
  - Load extraction: shift rdata right by addr[1:0]*8, then:
    - B sign-extends bits [7:0]; BU zero-extends [7:0].
    - H sign-extends [15:0]; HU zero-extends [15:0].
    - W passes the shifted word.
- WR_REQ:
  - awvalid and wvalid asserted together on entry.
  - Each deasserts independently on its own handshake; handshakes may complete in either order or in the same cycle.
  - Move to WR_RESP when both are done.
- Store lane generation:
  - B: wdata = {4{data[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{data[15:0]}}, wstrb = 0011 << {addr[1],1'b0}.
  - W: wdata = data, wstrb = 1111.
- WR_RESP: bready=1. On bvalid -> DONE; lsu_result <= 0.
- DONE:
  - lsu_finished=1, lsu_result held.
  - On ls_to_wb -> IDLE, and lsu_finished falls the next cycle.
  - If ex_to_ls coincides with ls_to_wb, the new instruction is accepted directly, as in IDLE.
  - ex_to_ls in DONE without ls_to_wb is ignored.
- lsu_busy = state not in {IDLE, DONE}. ex_to_ls while busy is ignored.
- Latency, counting from the ex_to_ls edge:
  - Non-memory: finished at cycle 1.
  - Load with zero-wait slave: arvalid at cycle 1, rready at cycle 2, finished at cycle 3.
  - Store with zero-wait slave: finished at cycle 3.

Optional Feature:
- Macro: YSYX_23060077_LSU_FAULT_EN.
- Defined:
  - A misaligned access (H with addr[0]=1, or W with addr[1:0]!=0) issues no bus transaction and goes IDLE -> DONE with lsu_fault=1 and lsu_result=0.
  - rresp or bresp != 00 sets lsu_fault=1 in DONE.
  - lsu_fault clears with lsu_finished.
- Undefined:
  - lsu_fault tied 0.
  - Misaligned accesses are issued as-is using the lane rules above.
  - Response codes are ignored.

Decomposition:
- Shared define file holds:
  - funct3 size codes (B/H/W/BU/HU);
  - FSM state encodings (one-hot, 6 bits);
  - AXI resp codes (OKAY=00);
  - DATA_WIDTH/ADDR_WIDTH macros.
- One combinational sub-module, ysyx_23060077_lsu_align: load extract/extend plus store wdata/wstrb generation.

Test Plan:
- Non-memory path: exu_result=0x1234_5678, mem_ren=mem_wen=0 -> lsu_finished at cycle 1, lsu_result=0x12345678, no bus valids.
- Load LB: addr=0x8000_0003, rdata=0x80FF_0000 -> lsu_result=0xFFFF_FF80. Same access with LBU -> 0x0000_0080.
- Load LH with arready delayed 3 cycles: addr=0x8000_0002, rdata=0xBEEF_1234 -> araddr stable while waiting; lsu_result=0xFFFF_BEEF.
- Store SB: addr=...01, data=0xAB -> wdata=0xABAB_ABAB, wstrb=0010. Test awready before wready, and the reverse order; exactly one transaction is issued.
- Back-to-back: ls_to_wb and ex_to_ls asserted in the same DONE cycle -> new load accepted without a bubble. Reset asserted in RD_DATA -> all valid/ready outputs 0 the next cycle and the FSM returns to IDLE.
- With YSYX_23060077_LSU_FAULT_EN: LW at addr=0x...02 -> no arvalid, lsu_fault=1 at cycle 1. bresp=10 -> lsu_fault=1.
